// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32/RV64 immediate generator with a 2-entry elastic buffer.
//
// Decodes the instruction as it enters the block. Only the decoded fields
// (imm/fmt/illegal/tag) are stored, in an output register plus one skid
// register. in_ready is registered, so there is no combinational path from
// out_ready back to in_ready.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous discard of all held entries
//   in_valid/in_ready   instruction handshake; in_inst, in_tag
//   out_valid/out_ready result handshake; out_imm, out_fmt, out_illegal, out_tag
//   out_fmt codes: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 SH

// Combinational immediate decoder.
module imm_gen_dec #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);
  localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                         F_U = 3'd4, F_J = 3'd5, F_Z = 3'd6, F_SH = 3'd7;
  localparam bit RV64 = (XLEN == 64);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       is_shift;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt, shamt_w, zimm;

  assign opc      = inst[6:0];
  assign f3       = inst[14:12];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  // Signed casts sign-extend from inst[31] up to XLEN.
  assign imm_i   = XLEN'($signed(inst[31:20]));
  assign imm_s   = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b   = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u   = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j   = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
  // RV64 OP-IMM shifts carry a 6-bit shamt; the *W forms keep 5 bits.
  assign shamt   = RV64 ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
  assign shamt_w = XLEN'(inst[24:20]);
  assign zimm    = XLEN'(inst[19:15]);

  always_comb begin
    imm     = '0;
    fmt     = F_NONE;
    illegal = 1'b0;
    case (opc)
      7'b0000011, 7'b1100111: begin fmt = F_I; imm = imm_i; end
      7'b0010011: begin
        if (is_shift) begin fmt = F_SH; imm = shamt; end
        else          begin fmt = F_I;  imm = imm_i; end
      end
      7'b0011011: begin
        if (!RV64)         illegal = 1'b1;
        else if (is_shift) begin fmt = F_SH; imm = shamt_w; end
        else               begin fmt = F_I;  imm = imm_i;   end
      end
      7'b0100011:             begin fmt = F_S; imm = imm_s; end
      7'b1100011:             begin fmt = F_B; imm = imm_b; end
      7'b0110111, 7'b0010111: begin fmt = F_U; imm = imm_u; end
      7'b1101111:             begin fmt = F_J; imm = imm_j; end
      7'b0110011, 7'b0001111: ;  // register/fence forms: no immediate
      7'b0111011:             illegal = !RV64;
      7'b1110011: begin
        if (f3[2]) begin fmt = F_Z; imm = zimm;  end
        else       begin fmt = F_I; imm = imm_i; end
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } ent_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state;
  ent_t   dec, head, skid;
  logic   acc, pop;

  imm_gen_dec #(.XLEN(XLEN)) u_dec (
    .inst    (in_inst),
    .imm     (dec.imm),
    .fmt     (dec.fmt),
    .illegal (dec.ill)
  );
  assign dec.tag = in_tag;

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  // head is always the oldest entry; skid only fills when head is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      head      <= '0;
      skid      <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          head <= dec; state <= ONE; out_valid <= 1'b1; in_ready <= 1'b1;
        end
        ONE: begin
          case ({acc, pop})
            2'b10: begin
              skid <= dec; state <= TWO; out_valid <= 1'b1; in_ready <= 1'b0;
            end
            2'b01: begin
              state <= EMPTY; out_valid <= 1'b0; in_ready <= 1'b1;
            end
            2'b11: begin
              head <= dec; state <= ONE; out_valid <= 1'b1; in_ready <= 1'b1;
            end
            default: ;
          endcase
        end
        TWO: if (pop) begin
          head <= skid; state <= ONE; out_valid <= 1'b1; in_ready <= 1'b1;
        end
        default: begin
          state <= EMPTY; out_valid <= 1'b0; in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign out_imm     = head.imm;
  assign out_fmt     = head.fmt;
  assign out_illegal = head.ill;
  assign out_tag     = head.tag;
endmodule
